// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit restoring divider controller for DIV/DIVU, returning {remainder, quotient}.
// Optional macro DIV_BYZERO_FAST_EN: a zero divisor short-cuts through BYZERO with a zero result.
`timescale 1ns/1ps
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

`ifdef DIV_BYZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t             state, state_nxt;
    logic [5:0]         cnt;
    logic [64:0]        dividend_r;
    logic [31:0]        divisor_r;
    logic               signed_r;
    logic               neg_dvd_r;
    logic               neg_dvs_r;
    logic [63:0]        res_r;
    logic signed [32:0] diff;
    logic               ready_d;
    logic [63:0]        result_d;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Quotient takes the sign of dvd^dvs, remainder follows the dividend; 0x80000000 wraps.
    function automatic logic [63:0] sign_fix(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic is_signed, input logic neg_dvd,
                                             input logic neg_dvs);
        logic [31:0] q;
        logic [31:0] r;
        q = (is_signed && (neg_dvd ^ neg_dvs)) ? (~quo + 32'd1) : quo;
        r = (is_signed && neg_dvd) ? (~rem + 32'd1) : rem;
        return {r, q};
    endfunction

    assign diff = $signed({1'b0, dividend_r[63:32]}) - $signed({1'b0, divisor_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= (state == ON && state_nxt == ON) ? cnt + 6'd1 : 6'd0;
            ready_o  <= ready_d;
            result_o <= result_d;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FREE: begin
                if (start_i && !annul_i)
                    state_nxt = (FAST_ZERO && opdata2_i == 32'd0) ? BYZERO : ON;
            end
            BYZERO: state_nxt = annul_i ? FREE : END;
            ON: begin
                if (annul_i || !start_i)
                    state_nxt = FREE;
                else if (cnt == 6'd32)
                    state_nxt = END;
            end
            END: begin
                if (annul_i || !start_i)
                    state_nxt = FREE;
            end
        endcase
    end

    // Outputs only assert while the finished result is being held for EX.
    always_comb begin
        ready_d  = 1'b0;
        result_d = 64'd0;
        if (state == END && state_nxt == END) begin
            ready_d  = 1'b1;
            result_d = res_r;
        end
    end

    always_ff @(posedge clk) begin
        unique case (state)
            FREE: begin
                if (state_nxt != FREE) begin
                    signed_r   <= signed_div_i;
                    neg_dvd_r  <= signed_div_i & opdata1_i[31];
                    neg_dvs_r  <= signed_div_i & opdata2_i[31];
                    dividend_r <= {32'd0, magnitude(opdata1_i, signed_div_i), 1'b0};
                    divisor_r  <= magnitude(opdata2_i, signed_div_i);
                end
            end
            BYZERO: begin
                dividend_r <= 65'd0;
                res_r      <= 64'd0;
            end
            ON: begin
                if (cnt == 6'd32) begin
                    res_r <= sign_fix(dividend_r[64:33], dividend_r[31:0],
                                      signed_r, neg_dvd_r, neg_dvs_r);
                end else if (diff[32]) begin
                    dividend_r <= {dividend_r[63:0], 1'b0};
                end else begin
                    dividend_r <= {diff[31:0], dividend_r[31:0], 1'b1};
                end
            end
            END: begin
            end
        endcase
    end

endmodule
